// File: rtl/ex_result_stage.sv
// EX-stage result collector: priority-selects one of NUM_FU unit results,
// registers it with its destination tag and hands it to WB over valid/ready.
// Optional zero-latency bypass lane (FU BYP_IDX) skips the register when the
// stage is empty and WB is ready. BYP_IDX >= NUM_FU disables the bypass.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   fu_valid_i       per-FU result valid
//   fu_result_i      packed results, FU k at [k*XLEN +: XLEN]
//   fu_tag_i         packed destination tags, same packing
//   ready_o          stage can accept a result this cycle
//   valid_o          result_o/tag_o valid towards WB
//   result_o, tag_o  selected result and its destination tag
//   ready_i          WB accepts this cycle
//   conflict_o       sticky: more than one FU valid while accepting
//   stall_cnt_o      saturating stall counter (EX_STALL_CNT_EN only)
// Optional feature macro: EX_STALL_CNT_EN.
module ex_result_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FU  = 6,
    parameter int TAG_W   = 5,
    parameter int BYP_IDX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_FU-1:0]       fu_valid_i,
    input  logic [NUM_FU*XLEN-1:0]  fu_result_i,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [XLEN-1:0]         result_o,
    output logic [TAG_W-1:0]        tag_o,
    input  logic                    ready_i,
`ifdef EX_STALL_CNT_EN
    output logic [15:0]             stall_cnt_o,
`endif
    output logic                    conflict_o
);

    localparam int SEL_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              conflict_q, conflict_d;

    logic [SEL_W-1:0]  sel;
    logic [XLEN-1:0]   sel_res;
    logic [TAG_W-1:0]  sel_tag;
    logic              any;
    logic              multi;
    logic              accept;
    logic              load;
    logic              byp_take;
    logic [XLEN-1:0]   byp_res;
    logic [TAG_W-1:0]  byp_tag;

    // Lowest index wins: scan from the top so lower indices overwrite.
    always_comb begin
        sel     = '0;
        sel_res = '0;
        sel_tag = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (fu_valid_i[k]) begin
                sel     = SEL_W'(k);
                sel_res = fu_result_i[k*XLEN +: XLEN];
                sel_tag = fu_tag_i[k*TAG_W +: TAG_W];
            end
        end
    end

    assign any     = |fu_valid_i;
    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign multi   = |(fu_valid_i & (fu_valid_i - NUM_FU'(1)));
    assign ready_o = ~valid_q | ready_i;
    assign accept  = any & ready_o;

    generate
        if (BYP_IDX < NUM_FU) begin : g_byp
            assign byp_take = accept & (sel == SEL_W'(BYP_IDX))
                            & ~valid_q & ready_i;
            assign byp_res  = fu_result_i[BYP_IDX*XLEN +: XLEN];
            assign byp_tag  = fu_tag_i[BYP_IDX*TAG_W +: TAG_W];
        end else begin : g_nobyp
            assign byp_take = 1'b0;
            assign byp_res  = '0;
            assign byp_tag  = '0;
        end
    endgenerate

    // A bypassed result leaves the stage this cycle; never register it.
    assign load = accept & ~byp_take;

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        tag_d      = tag_q;
        conflict_d = conflict_q | (multi & ready_o);
        if (load) begin
            valid_d = 1'b1;
            data_d  = sel_res;
            tag_d   = sel_tag;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            tag_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            tag_q      <= tag_d;
            conflict_q <= conflict_d;
        end
    end

    assign valid_o    = valid_q | byp_take;
    assign result_o   = byp_take ? byp_res : data_q;
    assign tag_o      = byp_take ? byp_tag : tag_q;
    assign conflict_o = conflict_q;

`ifdef EX_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (valid_o && !ready_i && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule
